// File: rtl/bcd_arb_pkg.sv
// Shared types and helpers for the round-robin BCD decoder arbiter.
// The decoder self-check is built only when BCD_ARB_CHECK_EN is defined.
package bcd_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned DEC_W   = 9;
  localparam int unsigned CNT_W   = 4;

  // One-hot {B9..B1} a healthy decoder produces for digit d; zero for d=0.
  function automatic logic [DEC_W-1:0] bcd_expect(input logic [3:0] d);
    if (d == 4'd0 || 32'(d) > BCD_MAX) return '0;
    return DEC_W'(1) << (d - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, circular.
module bcd_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  logic [IDW-1:0] j;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    j        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = IDW'((32'(ptr) + k) % NREQ);
      if (!any_c && req[j]) begin
        any_c       = 1'b1;
        idx_c       = j;
        onehot_c[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_dec_arbiter.sv
// Round-robin arbiter sharing one BCD-to-decimal decoder between NREQ requesters.
// Define BCD_ARB_CHECK_EN to add the decoder pattern check and chk_fail output.
module bcd_dec_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_digit,
  output logic [NREQ-1:0]   gnt,
  output logic              A1,
  output logic              A2,
  output logic              A4,
  output logic              A8,
  input  logic              B1,
  input  logic              B2,
  input  logic              B3,
  input  logic              B4,
  input  logic              B5,
  input  logic              B6,
  input  logic              B7,
  input  logic              B8,
  input  logic              B9,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [DEC_W-1:0]  rsp_dec,
  output logic              rsp_err
`ifdef BCD_ARB_CHECK_EN
  ,
  output logic              chk_fail
`endif
);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [3:0]       a_q, a_d;
  logic             vld_q, vld_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BCD_ARB_CHECK_EN
  logic             chk_q, chk_d;
`endif

  logic [NREQ-1:0]  pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [3:0]       digits [NREQ];
  logic [3:0]       sel_digit;
  logic [DEC_W-1:0] b_vec;

  assign b_vec = {B9, B8, B7, B6, B5, B4, B3, B2, B1};

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) digits[i] = req_digit[4*i +: 4];
  end

  assign sel_digit = digits[pick_idx];

  bcd_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .onehot_c (pick_oh),
    .idx_c    (pick_idx),
    .any_c    (pick_any)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      dec_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BCD_ARB_CHECK_EN
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef BCD_ARB_CHECK_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    a_d     = a_q;
    vld_d   = vld_q;
    id_d    = id_q;
    dec_d   = dec_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef BCD_ARB_CHECK_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        a_d = '0;
        if (pick_any) begin
          gnt_d = pick_oh;
          id_d  = pick_idx;
          cnt_d = '0;
          if (32'(sel_digit) <= BCD_MAX) begin
            a_d     = sel_digit;
            state_d = ST_DRIVE;
          end else begin
            err_d   = 1'b1;
            dec_d   = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_DRIVE: begin
        if (32'(cnt_q) == SETTLE - 1) state_d = ST_CAPT;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_CAPT: begin
        dec_d   = b_vec;
        err_d   = 1'b0;
        vld_d   = 1'b1;
        state_d = ST_RESP;
`ifdef BCD_ARB_CHECK_EN
        if (b_vec != bcd_expect(a_q)) begin
          chk_d = 1'b1;
          err_d = 1'b1;
        end
`endif
      end
      ST_RESP: begin
        // Invalid digits arrive here with valid still low; raise it one cycle later.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (rsp_ready) begin
          vld_d   = 1'b0;
          ptr_d   = (32'(id_q) == NREQ - 1) ? '0 : id_q + IDW'(1);
          a_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign A1        = a_q[0];
  assign A2        = a_q[1];
  assign A4        = a_q[2];
  assign A8        = a_q[3];
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_dec   = dec_q;
  assign rsp_err   = err_q;
`ifdef BCD_ARB_CHECK_EN
  assign chk_fail  = chk_q;
`endif

endmodule
